// File: rtl/gpr_ctrl_pkg.sv
// Shared definitions for the GPR write-port control slice: register file
// geometry, the architectural zero register and the clear-sweep state type.
package gpr_ctrl_pkg;

  localparam int GPR_AW = 5;
  localparam int GPR_N  = 32;
  localparam logic [GPR_AW-1:0] GPR_ZERO = 5'd0;

  // States of the register-file clear sweep
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    TAIL  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/gpr_clear_seq.sv
// Clear-sweep sequencer: on a clr_start pulse walks idx over every register
// (one per cycle), then spends one TAIL cycle before returning to IDLE.
// Only instantiated when GPR_WR_ARB_CLEAR_EN is defined.
// Ports:
//   Clk, Reset      clock (rising edge), asynchronous active-low reset
//   clr_start       one-cycle request to begin a sweep (ignored unless IDLE)
//   clr_busy        sweep in progress (CLEAR or TAIL)
//   seq_we, seq_a3  sweep write request for the output register: (1, idx)
module gpr_clear_seq
  import gpr_ctrl_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              seq_we,
  output logic [GPR_AW-1:0] seq_a3
);

  localparam logic [GPR_AW-1:0] IDX_LAST = GPR_AW'(GPR_N - 1);

  clr_state_e        state_q, state_d;
  logic [GPR_AW-1:0] idx_q, idx_d;

  // Sweep state and register index
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= GPR_ZERO;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: one register per CLEAR cycle, then a single TAIL cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          idx_d   = GPR_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == IDX_LAST) begin
          state_d = TAIL;
        end else begin
          state_d = CLEAR;
        end
      end
      TAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy = (state_q != IDLE);
  assign seq_we   = (state_q == CLEAR);
  assign seq_a3   = idx_q;

endmodule

// File: rtl/gpr_wr_arbiter.sv
// Write-port sequencer for the 32x32 GPR file. Arbitrates pipeline writeback
// (req0) against mult/div writeback (req1) with a starvation guard for req1,
// drops writes to $0, and registers the selected write onto RegWrite/A3/Wd.
// Optional feature macro: GPR_WR_ARB_CLEAR_EN adds a 32-cycle clear sweep.
// Ports:
//   Clk, Reset                         clock, asynchronous active-low reset
//   reqN_valid/addr/data, reqN_ready   valid/ready writeback requesters
//   clr_start, clr_busy                clear sweep start pulse / in progress
//   gpr_we, gpr_a3, gpr_wd             registered register-file write port
module gpr_wr_arbiter
  import gpr_ctrl_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          gpr_we,
  output logic [AW-1:0] gpr_a3,
  output logic [DW-1:0] gpr_wd
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              clr_busy_s;
  logic              block_s;
  logic              seq_we_s;
  logic [GPR_AW-1:0] seq_a3_s;
  logic              grant1_s;
  logic              xfer0_s, xfer1_s;
  logic [3:0]        starve_q, starve_d;
  logic              we_q, we_d;
  logic [AW-1:0]     a3_q, a3_d;
  logic [DW-1:0]     wd_q, wd_d;

`ifdef GPR_WR_ARB_CLEAR_EN
  gpr_clear_seq u_clear_seq (
    .Clk       (Clk),
    .Reset     (Reset),
    .clr_start (clr_start),
    .clr_busy  (clr_busy_s),
    .seq_we    (seq_we_s),
    .seq_a3    (seq_a3_s)
  );
  // Requesters are shut out from the start pulse until the sweep has ended.
  assign block_s = clr_busy_s | clr_start;
`else
  logic unused_clr_start_s;
  assign unused_clr_start_s = clr_start;
  assign clr_busy_s = 1'b0;
  assign seq_we_s   = 1'b0;
  assign seq_a3_s   = GPR_ZERO;
  assign block_s    = 1'b0;
`endif

  // req1 wins only when starved, or when req0 is not asking
  assign grant1_s   = req1_valid & ((starve_q == STARVE_LIM) | ~req0_valid);
  assign req0_ready = req0_valid & ~grant1_s & ~block_s;
  assign req1_ready = req1_valid &  grant1_s & ~block_s;
  assign xfer0_s    = req0_valid & req0_ready;
  assign xfer1_s    = req1_valid & req1_ready;

  // Starvation counter: counts denied req1 cycles, frozen during a sweep
  always_comb begin
    starve_d = starve_q;
    if (xfer1_s) begin
      starve_d = 4'd0;
    end else if (req1_valid && !clr_busy_s && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Output register next value: sweep, then accepted request, else idle
  always_comb begin
    we_d = 1'b0;
    a3_d = a3_q;
    wd_d = wd_q;
    if (seq_we_s) begin
      we_d = 1'b1;
      a3_d = AW'(seq_a3_s);
      wd_d = {DW{1'b0}};
    end else if (xfer0_s) begin
      we_d = (req0_addr != {AW{1'b0}});
      a3_d = req0_addr;
      wd_d = req0_data;
    end else if (xfer1_s) begin
      we_d = (req1_addr != {AW{1'b0}});
      a3_d = req1_addr;
      wd_d = req1_data;
    end else begin
      we_d = 1'b0;
    end
  end

  // Arbitration state and registered write port
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      starve_q <= 4'd0;
      we_q     <= 1'b0;
      a3_q     <= {AW{1'b0}};
      wd_q     <= {DW{1'b0}};
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      a3_q     <= a3_d;
      wd_q     <= wd_d;
    end
  end

  assign clr_busy = clr_busy_s;
  assign gpr_we   = we_q;
  assign gpr_a3   = a3_q;
  assign gpr_wd   = wd_q;

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Directed bench for gpr_wr_arbiter. Each step drives one cycle of stimulus,
// checks readies/busy against the step's expectation and pushes the write
// expected on the port one cycle later; that entry is popped next step.
module tb_gpr_wr_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        clr_start, clr_busy;
  logic        gpr_we;
  logic [4:0]  gpr_a3;
  logic [31:0] gpr_wd;

  int checks   = 0;
  int failures = 0;

  logic [37:0] exp_q[$];
  logic [4:0]  last_a3;
  logic [31:0] last_wd;

  gpr_wr_arbiter #(.DW(32), .AW(5), .STARVE_MAX(3)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .gpr_we     (gpr_we),
    .gpr_a3     (gpr_a3),
    .gpr_wd     (gpr_wd)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered 1 time unit after a rising edge.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic clr, input logic e_r0, input logic e_r1,
                      input logic e_busy, input logic sw, input logic [4:0] sidx);
    logic [37:0] e;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clr_start  = clr;
    @(negedge Clk);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("gpr_we", {63'd0, gpr_we}, {63'd0, e[37]});
      chk("gpr_a3", {59'd0, gpr_a3}, {59'd0, e[36:32]});
      chk("gpr_wd", {32'd0, gpr_wd}, {32'd0, e[31:0]});
    end
    chk("req0_ready", {63'd0, req0_ready}, {63'd0, e_r0});
    chk("req1_ready", {63'd0, req1_ready}, {63'd0, e_r1});
    chk("clr_busy",   {63'd0, clr_busy},   {63'd0, e_busy});
    if (sw) begin
      last_a3 = sidx; last_wd = 32'd0;
      exp_q.push_back({1'b1, sidx, 32'd0});
    end else if (e_r0) begin
      last_a3 = a0; last_wd = d0;
      exp_q.push_back({(a0 != 5'd0), a0, d0});
    end else if (e_r1) begin
      last_a3 = a1; last_wd = d1;
      exp_q.push_back({(a1 != 5'd0), a1, d1});
    end else begin
      exp_q.push_back({1'b0, last_a3, last_wd});
    end
    @(posedge Clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    Reset = 1'b0;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    clr_start = 1'b0;
    last_a3 = 5'd0; last_wd = 32'd0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    exp_q.push_back({1'b0, 5'd0, 32'd0});

    // Reset values, then a lone req0 write with one-cycle latency
    idle();
    step(1'b1, 5'd8, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    idle();
    idle();

    // Both valid: req0 x3, then starved req1, then req0; pending req1 next
    step(1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd9,  32'hB000_0009, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd2, 32'hA000_0002, 1'b1, 5'd9,  32'hB000_0009, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd3, 32'hA000_0003, 1'b1, 5'd9,  32'hB000_0009, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd4, 32'hA000_0004, 1'b1, 5'd9,  32'hB000_0009, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd4, 32'hA000_0004, 1'b1, 5'd10, 32'hB000_000A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'd0,         1'b1, 5'd10, 32'hB000_000A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);

    // Writes to $0 are accepted but never assert gpr_we
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

    // Counter restarted from 0 after the req1 transfers: 3 x req0 then req1
    step(1'b1, 5'd11, 32'hC000_000B, 1'b1, 5'd21, 32'hD000_0015, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd12, 32'hC000_000C, 1'b1, 5'd21, 32'hD000_0015, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd13, 32'hC000_000D, 1'b1, 5'd21, 32'hD000_0015, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd14, 32'hC000_000E, 1'b1, 5'd21, 32'hD000_0015, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd14, 32'hC000_000E, 1'b0, 5'd0,  32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    idle();

`ifdef GPR_WR_ARB_CLEAR_EN
    // Sweep: grant in S-1 lands in S; sweep writes in S+2..S+33; grant at S+34
    step(1'b1, 5'd5, 32'h0000_0055, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd6, 32'h0000_0066, 1'b1, 5'd7, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 5'd6, 32'h0000_0066, 1'b1, 5'd7, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'(k));
    end
    step(1'b1, 5'd6, 32'h0000_0066, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b1, 5'd6, 32'h0000_0066, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'd0,         1'b1, 5'd7, 32'h0000_0077, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    idle();

    // Reset in the middle of a sweep, then a fresh sweep starts at idx 0
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'(k));
    end
    Reset = 1'b0;
    #1;
    chk("rst_gpr_we",   {63'd0, gpr_we},   64'd0);
    chk("rst_gpr_a3",   {59'd0, gpr_a3},   64'd0);
    chk("rst_clr_busy", {63'd0, clr_busy}, 64'd0);
    exp_q.delete();
    last_a3 = 5'd0; last_wd = 32'd0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    exp_q.push_back({1'b0, 5'd0, 32'd0});
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'(k));
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    idle();
`else
    // Without the sweep, clr_start has no effect on arbitration or busy
    step(1'b1, 5'd17, 32'h0000_1717, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 5'd0,  32'd0, 1'b1, 5'd18, 32'h0000_1818, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    idle();
    idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpr_wr_arbiter.md
# gpr_wr_arbiter

Sequences the single write port (RegWrite/A3/Wd) of the 32×32 general-purpose register file in the multicycle MIPS core. Arbitrates between two writeback requesters (pipeline writeback and the multiply/divide unit) with a starvation guard. Enforces `$0` as read-only zero. Optionally runs a 32-cycle clear sweep that replaces per-register reset logic in the register file.

## Interface
- DW, 32, data width
- AW, 5, register address width
- STARVE_MAX, 3, consecutive denied cycles of req1 before it takes priority (1..15)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset (asserted at 0)
- req0_valid  in  1  pipeline writeback request
- req0_addr  in  AW  destination register
- req0_data  in  DW  write data
- req0_ready  out  1  req0 accepted this cycle
- req1_valid, req1_addr, req1_data, req1_ready  same as req0, mult/div writeback
- clr_start  in  1  one-cycle pulse, start clear sweep
- clr_busy  out  1  clear sweep in progress
- gpr_we  out  1  to register file RegWrite
- gpr_a3  out  AW  to register file A3
- gpr_wd  out  DW  to register file Wd

## Operation
- Handshake is valid/ready. A transfer occurs when valid && ready. The requester holds addr and data stable while valid && !ready. Valid must not drop before acceptance.
- Readiness is combinational from arbitration state. At most one ready is high per cycle. Ready is never high without its valid.
- Priority: req0 wins by default. If starve_cnt == STARVE_MAX and req1_valid, req1 wins.
- starve_cnt (4 bits) increments when req1_valid && !req1_ready and cnt < STARVE_MAX. It clears on a req1 transfer.
- An accepted request loads the output register: gpr_we = (addr != 0), gpr_a3 = addr, gpr_wd = data.
- Writes to `$0` are accepted and dropped (gpr_we = 0).
- With no transfer, the output register loads gpr_we = 0. gpr_a3 and gpr_wd hold their values.
- Clear FSM states: IDLE, CLEAR, TAIL.
  - IDLE → CLEAR on clr_start; idx ← 0.
  - In CLEAR, the output register loads (1, idx, 0) each cycle and idx increments. After idx = 31 the FSM moves to TAIL.
  - TAIL → IDLE unconditionally.
- clr_busy = (state != IDLE).
- Both readies are forced to 0 when clr_start is high in IDLE, or whenever state != IDLE.
- clr_start during CLEAR or TAIL is ignored.
- starve_cnt freezes during the sweep.
- The sweep writes `$0` as well (value 0; harmless).

## Timing
- Reset values: gpr_we = 0, gpr_a3 = 0, gpr_wd = 0, req0_ready = req1_ready = 0 (no valids assumed under reset), clr_busy = 0, state = IDLE, starve_cnt = 0, idx = 0.
- Latency: transfer in cycle N → gpr_we/a3/wd driven in cycle N+1 → register updated on the edge ending N+1. Throughput is 1 write/cycle.
- Clear: clr_start in cycle S. CLEAR occupies S+1..S+32 and TAIL occupies S+33. The write of register k appears on gpr_we in cycle S+2+k (k = 31 at S+33). Requesters are denied S..S+33 and may transfer again from S+34.
- A write granted in cycle S-1 still appears in cycle S, so there is no collision with the sweep.
- Reset asserted mid-sweep aborts immediately to IDLE with outputs at their reset values. Partial register contents are not restored.
- Simultaneous valids with starve_cnt < STARVE_MAX: req0 granted, req1 counter increments.

## Configuration
- Macro GPR_WR_ARB_CLEAR_EN.
- Defined: clear FSM and idx counter compiled in, behaviour as above.
- Undefined: FSM absent. clr_start is ignored, clr_busy is tied to 0, and readies depend only on arbitration. Ports remain present.

## Structure
- Shared package gpr_ctrl_pkg:
  - GPR_AW = 5, GPR_N = 32, GPR_ZERO = 5'd0
  - clear-state enum (IDLE, CLEAR, TAIL)
- Sub-module gpr_clear_seq holds the FSM and idx. It outputs clr_busy, seq_we, seq_a3. It is instantiated only under GPR_WR_ARB_CLEAR_EN.
- The arbiter, starve counter and output register stay in gpr_wr_arbiter.

## Test plan
- Reset low 3 cycles, then high → all outputs 0, both readies 0 with valids low.
- req0 only: (addr 8, 0x1234_5678) in cycle N → req0_ready=1 in N. gpr_we=1, gpr_a3=8, gpr_wd=0x1234_5678 in N+1, and 0 in N+2.
- Both valids held for 5 cycles, STARVE_MAX=3 → grants req0, req0, req0, req1, req0. starve_cnt returns to 0 after the req1 grant.
- req1 (addr 0, 0xFFFF_FFFF) → req1_ready=1, gpr_we stays 0 next cycle.
- With macro: req0 granted (addr 5) in S-1, clr_start in S with both valids high → addr 5 written in S. Zero-writes to a3 = 0..31 in S+2..S+33. clr_busy high S+1..S+33. First grant at S+34.
- With macro: Reset pulled low at S+10 during a sweep → gpr_we=0 immediately, clr_busy=0. After release, a new clr_start restarts from idx 0.
